// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: opcodes, the NOP reset value of IR, PC mux selects
// and the fetch-unit state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int PCSEL_PLUS4  = 0;
  localparam int PCSEL_TARGET = 1;

  typedef enum logic [0:0] {
    IFU_IDLE = 1'b0,
    IFU_REQ  = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  // imem_req and imem_addr are held stable from the first request cycle until
  // the clock edge at which imem_ready is sampled high; that edge transfers
  // imem_rdata. imem_ready is ignored while imem_req is low.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch_program_counter.sv
// PC register with +4 adder, source mux, one-deep pending update slot used
// while a fetch is outstanding, and a sticky misaligned-target flag.
module program_counter
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              pcmux_N  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       idle_i,
  input  logic                       pcnextctl_i,
  input  logic [$clog2(pcmux_N)-1:0] pcmuxctl_i,
  input  logic [XLEN-1:0]            pc_target_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            pc_next_o,
  output logic [XLEN-1:0]            pc_plus4_o,
  output logic                       misalign_err_o
);

  localparam int SW = $clog2(pcmux_N);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_v_q, pend_v_d;
  logic [SW-1:0]   pend_sel_q, pend_sel_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            mis_q, mis_d;

  logic            upd_en;
  logic [SW-1:0]   upd_sel;
  logic [XLEN-1:0] upd_tgt;
  logic [XLEN-1:0] sel_val;
  logic            sel_hit;
  logic            misalign;

  assign pc_plus4_o = pc_q + XLEN'(4);

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_sel_d = pend_sel_q;
    pend_tgt_d = pend_tgt_q;
    upd_en     = 1'b0;
    upd_sel    = pcmuxctl_i;
    upd_tgt    = pc_target_i;
    // A fresh request in IDLE supersedes anything left in the slot.
    if (idle_i) begin
      pend_v_d = 1'b0;
      if (pcnextctl_i) begin
        upd_en = 1'b1;
      end else if (pend_v_q) begin
        upd_en  = 1'b1;
        upd_sel = pend_sel_q;
        upd_tgt = pend_tgt_q;
      end
    end else if (pcnextctl_i) begin
      pend_v_d   = 1'b1;
      pend_sel_d = pcmuxctl_i;
      pend_tgt_d = pc_target_i;
    end

    sel_val = pc_q;
    sel_hit = 1'b0;
    if (upd_en) begin
      if (upd_sel == SW'(PCSEL_PLUS4)) begin
        sel_val = pc_plus4_o;
        sel_hit = 1'b1;
      end else if (upd_sel == SW'(PCSEL_TARGET)) begin
        sel_val = upd_tgt;
        sel_hit = 1'b1;
      end
    end
    misalign = sel_hit && (sel_val[1:0] != 2'b00);
    pc_d     = (sel_hit && !misalign) ? sel_val : pc_q;
    mis_d    = mis_q | misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_sel_q <= '0;
      pend_tgt_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_sel_q <= pend_sel_d;
      pend_tgt_q <= pend_tgt_d;
      mis_q      <= mis_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_next_o      = pc_d;
  assign misalign_err_o = mis_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, IR and the IDLE/REQ fetch FSM with field decode.
// Define IFU_TIMEOUT_EN to abort fetches after TIMEOUT_CYCLES request cycles.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int              pcmux_N        = 2,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   instrre,
  input  logic                                   pcnextctl,
  input  logic [$clog2(pcmux_N)-1:0]             pcmuxctl,
  input  logic [XLEN-1:0]                        pc_target,
  ifu_fetch_if.master                            imem,
  output logic [XLEN-1:0]                        instr,
  output logic [6:0]                             opcode,
  output logic [2:0]                             func3,
  output logic                                   func7b5,
  output logic [4:0]                             rd,
  output logic [4:0]                             rs1,
  output logic [4:0]                             rs2,
  output logic [XLEN-1:0]                        pc,
  output logic [XLEN-1:0]                        pc_plus4,
  output logic                                   instr_valid,
  output logic                                   fetch_busy,
  output logic                                   misalign_err,
  output logic                                   bus_err,
  output ifu_state_e                             dbg_state_o,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]    dbg_wait_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_next;

  program_counter #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .pcmux_N  (pcmux_N)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .idle_i         (state_q == IFU_IDLE),
    .pcnextctl_i    (pcnextctl),
    .pcmuxctl_i     (pcmuxctl),
    .pc_target_i    (pc_target),
    .pc_o           (pc),
    .pc_next_o      (pc_next),
    .pc_plus4_o     (pc_plus4),
    .misalign_err_o (misalign_err)
  );

`ifdef IFU_TIMEOUT_EN
  logic [TO_W-1:0] wait_q, wait_d;
  logic            berr_q, berr_d;
  logic            timeout;

  assign timeout = (state_q == IFU_REQ) && !imem.imem_ready &&
                   (wait_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign wait_d  = (state_q == IFU_REQ && state_d == IFU_REQ) ? wait_q + TO_W'(1) : '0;
  assign berr_d  = berr_q | timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      berr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      berr_q <= berr_d;
    end
  end

  assign bus_err    = berr_q;
  assign dbg_wait_o = wait_q;
`else
  logic timeout;
  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
  assign dbg_wait_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    case (state_q)
      IFU_IDLE: begin
        // The address uses the post-update PC so a same-cycle PC change is fetched.
        if (instrre) begin
          state_d = IFU_REQ;
          valid_d = 1'b0;
          addr_d  = {pc_next[XLEN-1:2], 2'b00};
        end
      end
      IFU_REQ: begin
        if (imem.imem_ready) begin
          state_d = IFU_IDLE;
          ir_d    = imem.imem_rdata;
          valid_d = 1'b1;
        end else if (timeout) begin
          state_d = IFU_IDLE;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
    if (pc_next != pc) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFU_IDLE;
      ir_q    <= NOP_INSTR;
      valid_q <= 1'b0;
      addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign imem.imem_req  = (state_q == IFU_REQ);
  assign imem.imem_addr = addr_q;
  assign fetch_busy     = (state_q == IFU_REQ);
  assign instr_valid    = valid_q;
  assign dbg_state_o    = state_q;

  assign instr   = ir_q;
  assign opcode  = ir_q[6:0];
  assign func3   = ir_q[14:12];
  assign func7b5 = ir_q[30];
  assign rd      = ir_q[11:7];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetch latency, wait states, deferred PC update,
// misalignment, PC wrap, reset mid-fetch and (with IFU_TIMEOUT_EN) timeout.
module tb_ifu_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrre;
  logic        pcnextctl;
  logic [0:0]  pcmuxctl;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc, pc_plus4;
  logic        instr_valid, fetch_busy, misalign_err, bus_err;
  ifu_state_e  dbg_state;
  logic [4:0]  dbg_wait;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  ifu_fetch_if #(.XLEN(32)) imem ();

  ifu_fetch #(
    .XLEN(32), .RESET_PC(32'h0), .pcmux_N(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .instrre(instrre), .pcnextctl(pcnextctl),
    .pcmuxctl(pcmuxctl), .pc_target(pc_target), .imem(imem),
    .instr(instr), .opcode(opcode), .func3(func3), .func7b5(func7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .dbg_state_o(dbg_state), .dbg_wait_o(dbg_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mem_respond(input logic [31:0] data);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = data;
    exp_q.push_back(data);
  endtask

  task automatic chk_capture(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: empty expected queue", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, instr, e);
    end
  endtask

  initial begin
    rst = 1'b1; instrre = 1'b0; pcnextctl = 1'b0; pcmuxctl = 1'b0; pc_target = '0;
    imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instr, 32'h13);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_mis", 32'(misalign_err), 32'h0);
    chk("rst_berr", 32'(bus_err), 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    rst = 1'b0;

    // zero-wait fetch
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    chk("f0_req", 32'(imem.imem_req), 32'h1);
    chk("f0_addr", imem.imem_addr, 32'h0);
    chk("f0_state", 32'(dbg_state), 32'(IFU_REQ));
    mem_respond(32'h0050_0093);
    tick();
    imem.imem_ready = 1'b0;
    chk("f0_req_drop", 32'(imem.imem_req), 32'h0);
    chk("f0_valid", 32'(instr_valid), 32'h1);
    chk_capture("f0_ir");
    chk("f0_opcode", 32'(opcode), 32'h13);
    chk("f0_rd", 32'(rd), 32'h1);
    chk("f0_func3", 32'(func3), 32'h0);

    // three wait cycles
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    chk("f1_valid_clr", 32'(instr_valid), 32'h0);
    chk("f1_addr_c0", imem.imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f1_req_wait", 32'(imem.imem_req), 32'h1);
      chk("f1_addr_wait", imem.imem_addr, 32'h0);
    end
    mem_respond(32'h4020_8133);
    tick();
    imem.imem_ready = 1'b0;
    chk_capture("f1_ir");
    chk("f1_f7b5", 32'(func7b5), 32'h1);
    chk("f1_opcode", 32'(opcode), 32'h33);
    chk("f1_rs1", 32'(rs1), 32'h1);
    chk("f1_rs2", 32'(rs2), 32'h2);
    chk("f1_rd", 32'(rd), 32'h2);

    // PC update during REQ is deferred; the second request wins
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    pcnextctl = 1'b1; pcmuxctl = 1'b1; pc_target = 32'h200;
    tick();
    pc_target = 32'h100;
    chk("pd_pc_hold0", pc, 32'h0);
    chk("pd_addr0", imem.imem_addr, 32'h0);
    tick();
    pcnextctl = 1'b0;
    chk("pd_pc_hold1", pc, 32'h0);
    chk("pd_addr1", imem.imem_addr, 32'h0);
    mem_respond(32'h00a0_0113);
    tick();
    imem.imem_ready = 1'b0;
    chk("pd_pc_cap", pc, 32'h0);
    chk("pd_valid_cap", 32'(instr_valid), 32'h1);
    chk_capture("pd_ir");
    tick();
    chk("pd_pc_new", pc, 32'h100);
    chk("pd_valid_drop", 32'(instr_valid), 32'h0);
    chk("pd_plus4", pc_plus4, 32'h104);

    // same-cycle instrre and pcnextctl: fetch uses updated pc
    instrre = 1'b1; pcnextctl = 1'b1; pcmuxctl = 1'b0;
    tick();
    instrre = 1'b0; pcnextctl = 1'b0;
    chk("sim_pc", pc, 32'h104);
    chk("sim_addr", imem.imem_addr, 32'h104);
    chk("sim_req", 32'(imem.imem_req), 32'h1);
    mem_respond(32'h0000_0013);
    tick();
    imem.imem_ready = 1'b0;
    chk_capture("sim_ir");
    chk("sim_valid", 32'(instr_valid), 32'h1);

    // misaligned target
    pcnextctl = 1'b1; pcmuxctl = 1'b1; pc_target = 32'h102;
    tick();
    pcnextctl = 1'b0;
    chk("mis_pc", pc, 32'h104);
    chk("mis_flag", 32'(misalign_err), 32'h1);
    chk("mis_valid_kept", 32'(instr_valid), 32'h1);
    tick(); tick();
    chk("mis_sticky", 32'(misalign_err), 32'h1);

    // wrap at top of address space
    pcnextctl = 1'b1; pcmuxctl = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    chk("wrap_valid_drop", 32'(instr_valid), 32'h0);
    pcmuxctl = 1'b0;
    tick();
    pcnextctl = 1'b0;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_mis_sticky", 32'(misalign_err), 32'h1);

    // reset mid-REQ with a late ready
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    chk("rr_req", 32'(imem.imem_req), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem.imem_ready = 1'b0;
    chk("rr_pc", pc, 32'h0);
    chk("rr_ir", instr, 32'h13);
    chk("rr_valid", 32'(instr_valid), 32'h0);
    chk("rr_req_low", 32'(imem.imem_req), 32'h0);
    chk("rr_mis_clr", 32'(misalign_err), 32'h0);

    // memory never answers for 16 request cycles
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_c16", 32'(imem.imem_req), 32'h1);
    tick();
`ifdef IFU_TIMEOUT_EN
    chk("to_req_drop", 32'(imem.imem_req), 32'h0);
    chk("to_berr", 32'(bus_err), 32'h1);
    chk("to_ir", instr, 32'h13);
    chk("to_valid", 32'(instr_valid), 32'h0);
`else
    chk("to_req_hold", 32'(imem.imem_req), 32'h1);
    chk("to_berr_tied", 32'(bus_err), 32'h0);
    mem_respond(32'h0010_0093);
    tick();
    imem.imem_ready = 1'b0;
    chk_capture("to_ir_late");
    chk("to_valid_late", 32'(instr_valid), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
